bond_downsizer: RTL and testbench

- Reverse of the bonded-pair path: one 128-bit Avalon-MM bursting slave drives a single 64-bit Avalon-MM DDR master port.
- Each 128-bit beat is split into two consecutive 64-bit beats (low half first). Each pair of 64-bit read beats is packed back into one 128-bit beat.
- Sits between a 128-bit video/DMA master and one DDR controller when only one DDR channel is populated.

---
 rtl/bond_downsizer.sv | 191 +++++++++++++++++++
 tb/tb_bond_downsizer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bond_downsizer.sv
// rtl/bond_downsizer.sv - 128-bit Avalon-MM burst slave onto one 64-bit DDR master
//
// Purpose:
//   Each 128-bit write beat is issued as two 64-bit master beats (low half first).
//   Each pair of 64-bit read beats is packed back into one 128-bit slave beat.
//   Read bursts are fire-and-forget; responses are packed in arrival order.
//
// Ports:
//   csi_clk, rsi_reset          clock, asynchronous active-high reset
//   avs_slave_*                 128-bit bursting slave (address in 128-bit words)
//   avm_ddr_*                   64-bit bursting master (address in 64-bit words)

module bond_downsizer #(
   parameter int ADDR_W  = 26,
   parameter int BURST_W = 4
) (
   input  logic                csi_clk,
   input  logic                rsi_reset,
   input  logic [ADDR_W-1:0]   avs_slave_address,
   input  logic [15:0]         avs_slave_byteenable,
   input  logic                avs_slave_read,
   output logic [127:0]        avs_slave_readdata,
   output logic                avs_slave_readdatavalid,
   input  logic                avs_slave_write,
   input  logic [127:0]        avs_slave_writedata,
   output logic                avs_slave_waitrequest,
   input  logic [BURST_W-1:0]  avs_slave_burstcount,
   input  logic                avs_slave_beginbursttransfer,
   output logic [ADDR_W:0]     avm_ddr_address,
   output logic [7:0]          avm_ddr_byteenable,
   output logic                avm_ddr_read,
   input  logic [63:0]         avm_ddr_readdata,
   input  logic                avm_ddr_readdatavalid,
   output logic                avm_ddr_write,
   output logic [63:0]         avm_ddr_writedata,
   input  logic                avm_ddr_waitrequest,
   output logic [BURST_W:0]    avm_ddr_burstcount,
   output logic                avm_ddr_beginbursttransfer
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_LO  = 2'd1,
      WR_HI  = 2'd2,
      RD_CMD = 2'd3
   } state_t;

   localparam logic [BURST_W:0] ONE = 1;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   addr_q, addr_d;
   logic [BURST_W:0]  burst_q, burst_d;
   logic [BURST_W:0]  remaining_q, remaining_d;
   logic              first_q, first_d;
   logic              toggle_q, toggle_d;
   logic [63:0]       lo_q, lo_d;
   logic [127:0]      rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;

   logic              wr_go;
   logic              unused_begin;

   // Burst start is decoded from the IDLE state, so the slave marker is not needed.
   assign unused_begin = avs_slave_beginbursttransfer;

   // A master write beat completes when the slave offers it and DDR is not stalling.
   assign wr_go = avs_slave_write && !avm_ddr_waitrequest;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      burst_d     = burst_q;
      remaining_d = remaining_q;
      first_d     = first_q;
      toggle_d    = toggle_q;
      lo_d        = lo_q;
      rdata_d     = rdata_q;
      rvalid_d    = 1'b0;

      case (state_q)
         IDLE: begin
            // Read has priority when both requests appear together.
            if (avs_slave_read) begin
               addr_d  = {avs_slave_address, 1'b0};
               burst_d = {avs_slave_burstcount, 1'b0};
               state_d = RD_CMD;
            end else if (avs_slave_write) begin
               addr_d      = {avs_slave_address, 1'b0};
               burst_d     = {avs_slave_burstcount, 1'b0};
               remaining_d = {avs_slave_burstcount, 1'b0};
               first_d     = 1'b1;
               state_d     = WR_LO;
            end
         end
         WR_LO: begin
            if (wr_go) begin
               first_d     = 1'b0;
               remaining_d = remaining_q - ONE;
               state_d     = WR_HI;
            end
         end
         WR_HI: begin
            if (wr_go) begin
               remaining_d = remaining_q - ONE;
               state_d     = (remaining_q == ONE) ? IDLE : WR_LO;
            end
         end
         RD_CMD: begin
            if (!avm_ddr_waitrequest) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Read packing runs independently of the command FSM.
      if (avm_ddr_readdatavalid) begin
         if (!toggle_q) begin
            lo_d     = avm_ddr_readdata;
            toggle_d = 1'b1;
         end else begin
            rdata_d  = {avm_ddr_readdata, lo_q};
            rvalid_d = 1'b1;
            toggle_d = 1'b0;
         end
      end
   end

   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         burst_q     <= '0;
         remaining_q <= '0;
         first_q     <= 1'b0;
         toggle_q    <= 1'b0;
         lo_q        <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         burst_q     <= burst_d;
         remaining_q <= remaining_d;
         first_q     <= first_d;
         toggle_q    <= toggle_d;
         lo_q        <= lo_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
      end
   end

   always_comb begin
      avs_slave_waitrequest      = 1'b1;
      avm_ddr_read               = 1'b0;
      avm_ddr_write              = 1'b0;
      avm_ddr_beginbursttransfer = 1'b0;
      avm_ddr_writedata          = avs_slave_writedata[63:0];
      avm_ddr_byteenable         = 8'hFF;

      case (state_q)
         WR_LO: begin
            avm_ddr_write              = avs_slave_write;
            avm_ddr_writedata          = avs_slave_writedata[63:0];
            avm_ddr_byteenable         = avs_slave_byteenable[7:0];
            avm_ddr_beginbursttransfer = first_q && avs_slave_write;
         end
         WR_HI: begin
            // The slave beat is consumed only when its high half goes out.
            avm_ddr_write         = avs_slave_write;
            avm_ddr_writedata     = avs_slave_writedata[127:64];
            avm_ddr_byteenable    = avs_slave_byteenable[15:8];
            avs_slave_waitrequest = !wr_go;
         end
         RD_CMD: begin
            avm_ddr_read               = 1'b1;
            avm_ddr_beginbursttransfer = 1'b1;
            avs_slave_waitrequest      = avm_ddr_waitrequest;
         end
         default: begin
            avs_slave_waitrequest = 1'b1;
         end
      endcase
   end

   assign avm_ddr_address         = addr_q;
   assign avm_ddr_burstcount      = burst_q;
   assign avs_slave_readdata      = rdata_q;
   assign avs_slave_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_bond_downsizer.sv
// tb/tb_bond_downsizer.sv - scoreboard bench for bond_downsizer

module tb_bond_downsizer;

   localparam int ADDR_W  = 26;
   localparam int BURST_W = 4;

   logic                csi_clk = 1'b0;
   logic                rsi_reset = 1'b1;
   logic [ADDR_W-1:0]   avs_slave_address = '0;
   logic [15:0]         avs_slave_byteenable = '0;
   logic                avs_slave_read = 1'b0;
   logic [127:0]        avs_slave_readdata;
   logic                avs_slave_readdatavalid;
   logic                avs_slave_write = 1'b0;
   logic [127:0]        avs_slave_writedata = '0;
   logic                avs_slave_waitrequest;
   logic [BURST_W-1:0]  avs_slave_burstcount = '0;
   logic                avs_slave_beginbursttransfer = 1'b0;
   logic [ADDR_W:0]     avm_ddr_address;
   logic [7:0]          avm_ddr_byteenable;
   logic                avm_ddr_read;
   logic [63:0]         avm_ddr_readdata = '0;
   logic                avm_ddr_readdatavalid = 1'b0;
   logic                avm_ddr_write;
   logic [63:0]         avm_ddr_writedata;
   logic                avm_ddr_waitrequest = 1'b0;
   logic [BURST_W:0]    avm_ddr_burstcount;
   logic                avm_ddr_beginbursttransfer;

   always #5 csi_clk = ~csi_clk;

   bond_downsizer #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
      .csi_clk                      (csi_clk),
      .rsi_reset                    (rsi_reset),
      .avs_slave_address            (avs_slave_address),
      .avs_slave_byteenable         (avs_slave_byteenable),
      .avs_slave_read               (avs_slave_read),
      .avs_slave_readdata           (avs_slave_readdata),
      .avs_slave_readdatavalid      (avs_slave_readdatavalid),
      .avs_slave_write              (avs_slave_write),
      .avs_slave_writedata          (avs_slave_writedata),
      .avs_slave_waitrequest        (avs_slave_waitrequest),
      .avs_slave_burstcount         (avs_slave_burstcount),
      .avs_slave_beginbursttransfer (avs_slave_beginbursttransfer),
      .avm_ddr_address              (avm_ddr_address),
      .avm_ddr_byteenable           (avm_ddr_byteenable),
      .avm_ddr_read                 (avm_ddr_read),
      .avm_ddr_readdata             (avm_ddr_readdata),
      .avm_ddr_readdatavalid        (avm_ddr_readdatavalid),
      .avm_ddr_write                (avm_ddr_write),
      .avm_ddr_writedata            (avm_ddr_writedata),
      .avm_ddr_waitrequest          (avm_ddr_waitrequest),
      .avm_ddr_burstcount           (avm_ddr_burstcount),
      .avm_ddr_beginbursttransfer   (avm_ddr_beginbursttransfer)
   );

   typedef struct {
      logic [ADDR_W:0]  addr;
      logic [BURST_W:0] burst;
      logic [7:0]       be;
      logic [63:0]      data;
      logic             bb;
   } wbeat_t;

   typedef struct {
      logic [ADDR_W:0]  addr;
      logic [BURST_W:0] burst;
   } rcmd_t;

   wbeat_t        exp_w[$];
   rcmd_t         exp_rc[$];
   logic [127:0]  exp_rd[$];
   rcmd_t         jobs[$];

   int checks = 0;
   int failures = 0;

   int stall_mode = 0;
   int cyc = 0;
   bit half_mode = 0;
   bit resp_hold = 0;
   int parity = 0;
   bit rv_exp = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Contents of the modelled DDR at a 64-bit word address.
   function automatic logic [63:0] mem(input logic [ADDR_W:0] a);
      logic [31:0] x;
      x = 32'(a);
      return {x * 32'h9E3779B1, x ^ 32'h5A5A1234};
   endfunction

   // DDR stall generator.
   always @(posedge csi_clk) begin
      cyc++;
      #1;
      case (stall_mode)
         1:       avm_ddr_waitrequest = ($urandom_range(0, 2) == 0);
         2:       avm_ddr_waitrequest = (cyc % 3 == 0);
         default: avm_ddr_waitrequest = 1'b0;
      endcase
   end

   // DDR read responder: returns accepted bursts in order with random gaps.
   rcmd_t       job;
   logic [ADDR_W:0] r_addr = '0;
   int          r_left = 0;
   always @(posedge csi_clk) begin
      #1;
      avm_ddr_readdatavalid = 1'b0;
      if (rsi_reset) begin
         jobs.delete();
         r_left = 0;
      end else if (!resp_hold) begin
         if (r_left == 0 && jobs.size() > 0) begin
            job    = jobs.pop_front();
            r_addr = job.addr;
            r_left = half_mode ? 1 : int'(job.burst);
         end
         if (r_left > 0 && $urandom_range(0, 3) != 0) begin
            avm_ddr_readdatavalid = 1'b1;
            avm_ddr_readdata      = mem(r_addr);
            r_addr                = r_addr + 1'b1;
            r_left--;
         end
      end
   end

   // Master-side command monitor.
   rcmd_t  mrc;
   wbeat_t mwb;
   always @(negedge csi_clk) begin
      if (!rsi_reset) begin
         if (avm_ddr_read && !avm_ddr_waitrequest) begin
            if (exp_rc.size() == 0) begin
               fail_now("rd_cmd_unexpected");
            end else begin
               mrc = exp_rc.pop_front();
               check("rd_addr", avm_ddr_address, mrc.addr);
               check("rd_burst", avm_ddr_burstcount, mrc.burst);
               check("rd_begin", avm_ddr_beginbursttransfer, 1'b1);
               jobs.push_back(mrc);
            end
         end
         if (avm_ddr_write && !avm_ddr_waitrequest) begin
            if (exp_w.size() == 0) begin
               fail_now("wr_beat_unexpected");
            end else begin
               mwb = exp_w.pop_front();
               check("wr_addr", avm_ddr_address, mwb.addr);
               check("wr_burst", avm_ddr_burstcount, mwb.burst);
               check("wr_be", avm_ddr_byteenable, mwb.be);
               check("wr_data", avm_ddr_writedata, mwb.data);
               check("wr_begin", avm_ddr_beginbursttransfer, mwb.bb);
            end
         end
      end
   end

   // Slave-side read data monitor: data and one-cycle-after-hi timing.
   always @(negedge csi_clk) begin
      if (rsi_reset) begin
         parity = 0;
         rv_exp = 0;
      end else begin
         if (avs_slave_readdatavalid || rv_exp)
            check("rdv_timing", avs_slave_readdatavalid, rv_exp);
         if (avs_slave_readdatavalid) begin
            if (exp_rd.size() == 0) fail_now("rdata_unexpected");
            else check("rdata", avs_slave_readdata, exp_rd.pop_front());
         end
         rv_exp = 0;
         if (avm_ddr_readdatavalid) begin
            if (parity == 1) rv_exp = 1;
            parity ^= 1;
         end
      end
   end

   task automatic next_cycle();
      @(posedge csi_clk);
      #1;
   endtask

   task automatic wait_accept(output int lat);
      bit ok;
      ok  = 0;
      lat = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge csi_clk);
         lat++;
         if (!avs_slave_waitrequest) ok = 1;
         next_cycle();
      end
      if (!ok) fail_now("accept_timeout");
   endtask

   task automatic push_write(input logic [ADDR_W-1:0] a, input int n,
                             input logic [127:0] d, input logic [15:0] be, input bit first);
      wbeat_t b;
      b.addr  = {a, 1'b0};
      b.burst = (BURST_W+1)'(2 * n);
      b.be = be[7:0];  b.data = d[63:0];   b.bb = first;
      exp_w.push_back(b);
      b.be = be[15:8]; b.data = d[127:64]; b.bb = 1'b0;
      exp_w.push_back(b);
   endtask

   task automatic wr_burst(input logic [ADDR_W-1:0] a, input int n, input bit gaps,
                           input logic [127:0] d0, input logic [15:0] be0, input int exp_lat);
      logic [127:0] d;
      logic [15:0]  be;
      int lat;
      for (int k = 0; k < n; k++) begin
         if (k == 0) begin
            d = d0; be = be0;
         end else begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            be = 16'($urandom);
            if (gaps) begin
               avs_slave_write = 1'b0;
               repeat ($urandom_range(0, 2)) next_cycle();
            end
         end
         push_write(a, n, d, be, k == 0);
         avs_slave_write      = 1'b1;
         avs_slave_address    = a;
         avs_slave_burstcount = BURST_W'(n);
         avs_slave_writedata  = d;
         avs_slave_byteenable = be;
         wait_accept(lat);
         if (k == 0 && exp_lat > 0) check("wr_first_latency", lat, exp_lat);
      end
      avs_slave_write = 1'b0;
   endtask

   task automatic push_read(input logic [ADDR_W-1:0] a, input int n, input bit with_data);
      rcmd_t c;
      logic [ADDR_W:0] w;
      c.addr  = {a, 1'b0};
      c.burst = (BURST_W+1)'(2 * n);
      exp_rc.push_back(c);
      if (with_data) begin
         for (int k = 0; k < n; k++) begin
            w = c.addr + (ADDR_W+1)'(2 * k);
            exp_rd.push_back({mem(w + 1'b1), mem(w)});
         end
      end
   endtask

   task automatic rd_burst(input logic [ADDR_W-1:0] a, input int n, input bit with_data);
      int lat;
      push_read(a, n, with_data);
      avs_slave_read       = 1'b1;
      avs_slave_address    = a;
      avs_slave_burstcount = BURST_W'(n);
      wait_accept(lat);
      avs_slave_read = 1'b0;
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 3000; i++) begin
         if (exp_w.size() == 0 && exp_rc.size() == 0 && exp_rd.size() == 0 && jobs.size() == 0
             && r_left == 0)
            break;
         next_cycle();
      end
      if (i == 3000) fail_now("drain_timeout");
      repeat (3) next_cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdv"},   avs_slave_readdatavalid, 1'b0);
      check({tag, "_rdata"}, avs_slave_readdata, 128'h0);
      check({tag, "_wait"},  avs_slave_waitrequest, 1'b1);
      check({tag, "_read"},  avm_ddr_read, 1'b0);
      check({tag, "_write"}, avm_ddr_write, 1'b0);
      check({tag, "_begin"}, avm_ddr_beginbursttransfer, 1'b0);
      check({tag, "_addr"},  avm_ddr_address, '0);
      check({tag, "_burst"}, avm_ddr_burstcount, '0);
   endtask

   initial begin
      int lat;
      int i;
      repeat (2) @(posedge csi_clk);
      #1;
      check_reset_outputs("reset");
      rsi_reset = 1'b0;
      next_cycle();

      // Single write, fixed data, no stalls.
      stall_mode = 0;
      wr_burst(26'h10, 1, 0, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 16'hFFFF, 3);
      drain();

      // Write burst with periodic DDR stalls.
      stall_mode = 2;
      wr_burst(26'h123, 4, 0, {$urandom, $urandom, $urandom, $urandom}, 16'hA5C3, 0);
      drain();
      check("idle_after_burst", avs_slave_waitrequest, 1'b1);

      // Read N=2 at 0x5.
      stall_mode = 0;
      rd_burst(26'h5, 2, 1);
      drain();

      // Back-to-back reads before any data returns.
      resp_hold = 1;
      rd_burst(26'h40, 1, 1);
      rd_burst(26'h77, 8, 1);
      resp_hold = 0;
      drain();
      check("toggle_after_b2b", parity, 0);

      // Read and write asserted together: read goes first.
      avs_slave_read       = 1'b1;
      avs_slave_write      = 1'b1;
      avs_slave_address    = 26'h300;
      avs_slave_burstcount = 4'd1;
      avs_slave_writedata  = {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002};
      avs_slave_byteenable = 16'h0FF0;
      push_read(26'h300, 1, 1);
      push_write(26'h300, 1, avs_slave_writedata, avs_slave_byteenable, 1'b1);
      wait_accept(lat);
      check("rw_read_first", exp_rc.size(), 0);
      avs_slave_read = 1'b0;
      wait_accept(lat);
      avs_slave_write = 1'b0;
      drain();

      // Reset while in WR_HI with a half-packed read pending.
      half_mode = 1;
      rd_burst(26'h33, 1, 0);
      for (i = 0; i < 200 && parity != 1; i++) next_cycle();
      if (parity != 1) fail_now("half_beat_timeout");
      half_mode = 0;
      repeat (2) next_cycle();
      avs_slave_write      = 1'b1;
      avs_slave_address    = 26'h2AA;
      avs_slave_burstcount = 4'd2;
      avs_slave_writedata  = {$urandom, $urandom, $urandom, $urandom};
      avs_slave_byteenable = 16'hFFFF;
      exp_w.push_back('{addr: {26'h2AA, 1'b0}, burst: 5'd4, be: 8'hFF,
                        data: avs_slave_writedata[63:0], bb: 1'b1});
      next_cycle();
      next_cycle();
      check("in_wr_hi_wait", avs_slave_waitrequest, 1'b0);
      check("in_wr_hi_data", avm_ddr_writedata, avs_slave_writedata[127:64]);
      rsi_reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      avs_slave_write = 1'b0;
      next_cycle();
      next_cycle();
      rsi_reset = 1'b0;
      next_cycle();
      wr_burst(26'h2AB, 1, 0, {$urandom, $urandom, $urandom, $urandom}, 16'h3C3C, 3);
      rd_burst(26'h91, 1, 1);
      drain();

      // Randomized traffic with random stalls.
      stall_mode = 1;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 1) == 0)
            wr_burst(ADDR_W'($urandom), $urandom_range(1, 8), 1,
                     {$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 0);
         else
            rd_burst(ADDR_W'($urandom), $urandom_range(1, 8), 1);
         repeat ($urandom_range(0, 2)) next_cycle();
      end
      drain();
      check("final_toggle", parity, 0);
      check("final_exp_rd_empty", exp_rd.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
